// File: rtl/ternary_add_compare.sv
// Balanced-ternary ripple adder and signed comparator with one output register stage.
// Trits are 2-bit codes (00=0, 01=+1, 10=-1, 11 read as 0); trit 0 is least significant.
module ternary_add_compare #(
  parameter int WORD_SIZE = 9
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [2*WORD_SIZE-1:0] input1,
  input  logic [2*WORD_SIZE-1:0] input2,
  input  logic                   enable,
  input  logic                   in_valid,
  output logic [2*WORD_SIZE-1:0] result,
  output logic [1:0]             carry_out,
  output logic                   less_than,
  output logic                   out_valid
);

  function automatic logic signed [1:0] decode_trit(input logic [1:0] code);
    case (code)
      2'b01:   decode_trit = 2'sd1;
      2'b10:   decode_trit = -2'sd1;
      default: decode_trit = 2'sd0;
    endcase
  endfunction

  function automatic logic [1:0] encode_trit(input logic signed [2:0] value);
    if (value == 3'sd1)
      encode_trit = 2'b01;
    else if (value == -3'sd1)
      encode_trit = 2'b10;
    else
      encode_trit = 2'b00;
  endfunction

  logic signed [1:0]      carry_chain [WORD_SIZE+1];
  logic                   lt_chain    [WORD_SIZE+1];
  logic [2*WORD_SIZE-1:0] sum_next;

  assign carry_chain[0] = 2'sd0;
  assign lt_chain[0]    = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < WORD_SIZE; gi++) begin : g_trit
      logic signed [1:0] a_val;
      logic signed [1:0] b_val;
      logic signed [2:0] trit_sum;
      logic signed [2:0] digit;

      assign a_val = decode_trit(input1[2*gi +: 2]);
      assign b_val = decode_trit(input2[2*gi +: 2]);

      assign trit_sum = $signed({a_val[1], a_val}) + $signed({b_val[1], b_val})
                      + $signed({carry_chain[gi][1], carry_chain[gi]});

      // Fold the -3..+3 trit sum back into one digit plus a carry of +/-1.
      assign carry_chain[gi+1] = (trit_sum > 3'sd1)  ? 2'sd1 :
                                 (trit_sum < -3'sd1) ? -2'sd1 : 2'sd0;
      assign digit = (trit_sum > 3'sd1)  ? trit_sum - 3'sd3 :
                     (trit_sum < -3'sd1) ? trit_sum + 3'sd3 : trit_sum;
      assign sum_next[2*gi +: 2] = encode_trit(digit);

      // A differing higher trit overrides anything decided below it, so the
      // top of this chain is the verdict of the most significant differing trit.
      assign lt_chain[gi+1] = (a_val != b_val) ? (a_val < b_val) : lt_chain[gi];
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      result    <= '0;
      carry_out <= 2'b00;
      less_than <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (enable) begin
        result    <= '0;
        carry_out <= 2'b00;
        less_than <= 1'b0;
      end else begin
        result    <= sum_next;
        carry_out <= encode_trit($signed({carry_chain[WORD_SIZE][1], carry_chain[WORD_SIZE]}));
        less_than <= lt_chain[WORD_SIZE];
      end
    end
  end

endmodule

// File: tb/tb_ternary_add_compare.sv
// Directed-vector scoreboard bench for ternary_add_compare (WORD_SIZE = 9).
// Stimulus pushes hand-computed expectations; a monitor pops one per clock and compares.
module tb_ternary_add_compare;
  localparam int W = 9;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [2*W-1:0] input1 = '0;
  logic [2*W-1:0] input2 = '0;
  logic           enable = 1'b1;
  logic           in_valid = 1'b0;
  logic [2*W-1:0] result;
  logic [1:0]     carry_out;
  logic           less_than;
  logic           out_valid;

  typedef struct {
    string          name;
    logic [2*W-1:0] res;
    logic [1:0]     cout;
    logic           lt;
    logic           vld;
  } exp_t;

  exp_t exp_q[$];
  int   n_vectors = 0;
  int   n_miscompares = 0;

  ternary_add_compare #(.WORD_SIZE(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .input1    (input1),
    .input2    (input2),
    .enable    (enable),
    .in_valid  (in_valid),
    .result    (result),
    .carry_out (carry_out),
    .less_than (less_than),
    .out_valid (out_valid)
  );

  always #5 clock = ~clock;

  task automatic apply(input string name, input logic rst, input logic en, input logic iv,
                       input logic [2*W-1:0] a, input logic [2*W-1:0] b,
                       input logic [2*W-1:0] e_res, input logic [1:0] e_c,
                       input logic e_lt, input logic e_v);
    exp_t e;
    @(negedge clock);
    reset    = rst;
    enable   = en;
    in_valid = iv;
    input1   = a;
    input2   = b;
    e.name = name;
    e.res  = e_res;
    e.cout = e_c;
    e.lt   = e_lt;
    e.vld  = e_v;
    exp_q.push_back(e);
  endtask

  // Monitor: outputs settle one cycle after capture, sampled just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vectors++;
        if (result !== e.res || carry_out !== e.cout || less_than !== e.lt || out_valid !== e.vld) begin
          n_miscompares++;
          $display("FAIL %s: got res=%h c=%b lt=%b v=%b, want res=%h c=%b lt=%b v=%b",
                   e.name, result, carry_out, less_than, out_valid, e.res, e.cout, e.lt, e.vld);
        end else begin
          $display("ok   %s: res=%h c=%b lt=%b v=%b", e.name, result, carry_out, less_than, out_valid);
        end
      end
    end
  end

  initial begin
    //     name          rst   en    iv    A          B          result     cout   lt    vld
    apply("reset",       1'b1, 1'b0, 1'b1, 18'h15555, 18'h00001, 18'h00000, 2'b00, 1'b0, 1'b0);
    apply("min_plus1",   1'b0, 1'b0, 1'b1, 18'h2AAAA, 18'h00001, 18'h2AAA8, 2'b00, 1'b1, 1'b1);
    apply("wrap",        1'b0, 1'b0, 1'b1, 18'h15555, 18'h00001, 18'h2AAAA, 2'b01, 1'b0, 1'b1);
    apply("carry_chain", 1'b0, 1'b0, 1'b1, 18'h00001, 18'h00001, 18'h00006, 2'b00, 1'b0, 1'b1);
    apply("cmp_0_lt_1",  1'b0, 1'b0, 1'b1, 18'h00000, 18'h00001, 18'h00001, 2'b00, 1'b1, 1'b1);
    apply("cmp_swap",    1'b0, 1'b0, 1'b1, 18'h00001, 18'h00000, 18'h00001, 2'b00, 1'b0, 1'b1);
    apply("cmp_equal",   1'b0, 1'b0, 1'b1, 18'h15555, 18'h15555, 18'h00002, 2'b01, 1'b0, 1'b1);
    apply("enable_hi",   1'b0, 1'b1, 1'b1, 18'h00001, 18'h00001, 18'h00000, 2'b00, 1'b0, 1'b1);
    apply("no_valid",    1'b0, 1'b0, 1'b0, 18'h2AAAA, 18'h00001, 18'h2AAA8, 2'b00, 1'b1, 1'b0);
    apply("neg_carry",   1'b0, 1'b0, 1'b1, 18'h00002, 18'h00002, 18'h00009, 2'b00, 1'b0, 1'b1);
    apply("msb_decides", 1'b0, 1'b0, 1'b1, 18'h10002, 18'h00001, 18'h10000, 2'b00, 1'b0, 1'b1);
    apply("msb_neg",     1'b0, 1'b0, 1'b1, 18'h20000, 18'h15555, 18'h05555, 2'b00, 1'b1, 1'b1);
    apply("invalid_a",   1'b0, 1'b0, 1'b1, 18'h3FFFF, 18'h00001, 18'h00001, 2'b00, 1'b1, 1'b1);
    apply("invalid_eq",  1'b0, 1'b0, 1'b1, 18'h00003, 18'h00000, 18'h00000, 2'b00, 1'b0, 1'b1);
    apply("en_hi_noval", 1'b0, 1'b1, 1'b0, 18'h15555, 18'h00001, 18'h00000, 2'b00, 1'b0, 1'b0);
    apply("mid_reset",   1'b1, 1'b0, 1'b1, 18'h15555, 18'h00001, 18'h00000, 2'b00, 1'b0, 1'b0);
    apply("post_reset",  1'b0, 1'b0, 1'b1, 18'h15555, 18'h00001, 18'h2AAAA, 2'b01, 1'b0, 1'b1);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++)
      @(negedge clock);
    if (exp_q.size() > 0) begin
      n_vectors++;
      n_miscompares++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
